// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared memory-bus size codes, arbiter states and region limit
package riscv_mem_pkg;

    localparam logic [1:0] SZ_READ = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [31:0] RAM_LIMIT_DEFAULT = 32'h0002_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_WRITE_WAIT,
        ST_VGA_WRITE,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester-side bus of the memory arbiter (cpu and dbg ports)
interface mem_bus_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    logic                 cpu_req,    dbg_req;
    logic [1:0]           cpu_size,   dbg_size;
    logic [31:0]          cpu_addr,   dbg_addr;
    logic [WORD_SIZE-1:0] cpu_wdata,  dbg_wdata;
    logic                 cpu_gnt,    dbg_gnt;
    logic                 cpu_rvalid, dbg_rvalid;
    logic                 cpu_err,    dbg_err;
    logic [WORD_SIZE-1:0] rdata;

    modport master (
        output cpu_req, cpu_size, cpu_addr, cpu_wdata,
        output dbg_req, dbg_size, dbg_addr, dbg_wdata,
        input  cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err, rdata
    );

    modport slave (
        input  cpu_req, cpu_size, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_size, dbg_addr, dbg_wdata,
        output cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err, rdata
    );
endinterface

// File: rtl/mem_region_decode.sv
// rtl/mem_region_decode.sv - combinational RAM/VGA region and alignment decode
module mem_region_decode
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] RAM_LIMIT = RAM_LIMIT_DEFAULT
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        is_ram,
    output logic        is_vga,
    output logic        misaligned,
    output logic        read_illegal
);
    assign is_ram       = (addr < RAM_LIMIT);
    assign is_vga       = ~is_ram;
    assign misaligned   = ((size == SZ_HALF) && addr[0]) ||
                          ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign read_illegal = (size == SZ_READ) && is_vga;
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin cpu/dbg arbiter sequencing RAM reads/writes and VGA writes
module mem_bus_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int          WORD_SIZE    = 32,
    parameter logic [31:0] RAM_LIMIT    = RAM_LIMIT_DEFAULT,
    parameter int          READ_LATENCY = 2,
    parameter int          WR_TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_arbiter_if.slave     bus,
    output logic [31:0]          mem_address,
    output logic [1:0]           mem_write_mode,
    output logic [7:0]           mem_write_byte,
    output logic [15:0]          mem_write_half_word,
    output logic [WORD_SIZE-1:0] mem_write_word,
    input  logic [WORD_SIZE-1:0] mem_word_output,
    input  logic                 mem_done,
    input  logic                 mem_error,
    output logic                 vga_write_en,
    output logic [12:0]          vga_write_address,
    output logic [WORD_SIZE-1:0] vga_input_data
);
    localparam logic [7:0] RD_LAST = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_TIMEOUT - 1);

    arb_state_t           state_q, next_state;
    logic                 last_dbg_q, owner_dbg_q, err_q;
    logic [7:0]           cnt_q;
    logic [WORD_SIZE-1:0] rdata_q;

    logic                 pick_dbg, take;
    logic [1:0]           sel_size;
    logic [31:0]          sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic                 is_ram, is_vga, misaligned, read_illegal;

    // dbg wins only when it is alone or cpu was served last
    assign pick_dbg  = bus.dbg_req && (!bus.cpu_req || !last_dbg_q);
    assign sel_size  = pick_dbg ? bus.dbg_size  : bus.cpu_size;
    assign sel_addr  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;

    mem_region_decode #(.RAM_LIMIT(RAM_LIMIT)) u_decode (
        .addr         (sel_addr),
        .size         (sel_size),
        .is_ram       (is_ram),
        .is_vga       (is_vga),
        .misaligned   (misaligned),
        .read_illegal (read_illegal)
    );

    always_comb begin
        next_state  = state_q;
        take        = 1'b0;
        bus.cpu_gnt = 1'b0;
        bus.dbg_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    take        = 1'b1;
                    bus.cpu_gnt = ~pick_dbg;
                    bus.dbg_gnt = pick_dbg;
                    if (misaligned || read_illegal)            next_state = ST_RESP;
                    else if ((sel_size == SZ_READ) && is_ram)  next_state = ST_READ_WAIT;
                    else if (is_vga)                           next_state = ST_VGA_WRITE;
                    else                                       next_state = ST_WRITE_WAIT;
                end
            end
            ST_READ_WAIT:  if (cnt_q == RD_LAST) next_state = ST_RESP;
            ST_WRITE_WAIT: if (mem_done || mem_error || (cnt_q == WR_LAST)) next_state = ST_RESP;
            ST_VGA_WRITE:  next_state = ST_RESP;
            ST_RESP:       next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    assign bus.cpu_rvalid = (state_q == ST_RESP) && !owner_dbg_q;
    assign bus.dbg_rvalid = (state_q == ST_RESP) &&  owner_dbg_q;
    assign bus.cpu_err    = bus.cpu_rvalid && err_q;
    assign bus.dbg_err    = bus.dbg_rvalid && err_q;
    assign bus.rdata      = (state_q == ST_RESP) ? rdata_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            last_dbg_q          <= 1'b1;
            owner_dbg_q         <= 1'b0;
            err_q               <= 1'b0;
            cnt_q               <= '0;
            rdata_q             <= '0;
            mem_address         <= '0;
            mem_write_mode      <= SZ_READ;
            mem_write_byte      <= '0;
            mem_write_half_word <= '0;
            mem_write_word      <= '0;
            vga_write_en        <= 1'b0;
            vga_write_address   <= '0;
            vga_input_data      <= '0;
        end else begin
            state_q <= next_state;
            case (state_q)
                ST_IDLE: if (take) begin
                    owner_dbg_q <= pick_dbg;
                    last_dbg_q  <= pick_dbg;
                    cnt_q       <= '0;
                    rdata_q     <= '0;
                    err_q       <= misaligned || read_illegal;
                    if (next_state == ST_READ_WAIT) begin
                        mem_address <= sel_addr;
                    end else if (next_state == ST_WRITE_WAIT) begin
                        mem_address         <= sel_addr;
                        mem_write_mode      <= sel_size;
                        mem_write_byte      <= sel_wdata[7:0];
                        mem_write_half_word <= sel_wdata[15:0];
                        mem_write_word      <= sel_wdata;
                    end else if (next_state == ST_VGA_WRITE) begin
                        vga_write_en      <= 1'b1;
                        vga_write_address <= sel_addr[12:0];
                        vga_input_data    <= sel_wdata;
                    end
                end
                ST_READ_WAIT: begin
                    if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                    if (next_state == ST_RESP) rdata_q <= mem_word_output;
                end
                ST_WRITE_WAIT: begin
                    if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                    // error beats done; leaving with neither raised is the timeout
                    if (next_state == ST_RESP) begin
                        mem_write_mode <= SZ_READ;
                        err_q          <= mem_error || !mem_done;
                    end
                end
                ST_VGA_WRITE: vga_write_en <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic [1:0]  mem_write_mode;
    logic [7:0]  mem_write_byte;
    logic [15:0] mem_write_half_word;
    logic [31:0] mem_write_word;
    logic [31:0] mem_word_output;
    logic        mem_done, mem_error;
    logic        vga_write_en;
    logic [12:0] vga_write_address;
    logic [31:0] vga_input_data;

    int passed = 0;
    int total  = 0;
    int n;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .mem_address         (mem_address),
        .mem_write_mode      (mem_write_mode),
        .mem_write_byte      (mem_write_byte),
        .mem_write_half_word (mem_write_half_word),
        .mem_write_word      (mem_write_word),
        .mem_word_output     (mem_word_output),
        .mem_done            (mem_done),
        .mem_error           (mem_error),
        .vga_write_en        (vga_write_en),
        .vga_write_address   (vga_write_address),
        .vga_input_data      (vga_input_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic req_cpu(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = r; bus.cpu_size = s; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic req_dbg(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        bus.dbg_req = r; bus.dbg_size = s; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        req_cpu(0, 2'b00, 32'h0, 32'h0);
        req_dbg(0, 2'b00, 32'h0, 32'h0);
        mem_word_output = 32'h0;
        mem_done = 1'b0;
        mem_error = 1'b0;
        nc(); nc();
        rst = 1'b0;
        smp();
        chk("reset_gnt",    {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid}, 32'h0);
        chk("reset_rdata",  bus.rdata, 32'h0);
        chk("reset_addr",   mem_address, 32'h0);
        chk("reset_wmode",  mem_write_mode, 32'h0);
        chk("reset_vga_en", vga_write_en, 32'h0);

        // tie at cycle 0: cpu wins after reset
        nc();
        req_cpu(1, 2'b00, 32'h100, 32'h0);
        req_dbg(1, 2'b00, 32'h200, 32'h0);
        mem_word_output = 32'h1111_1111;
        smp();
        chk("tie0_cpu_gnt", bus.cpu_gnt, 32'h1);
        chk("tie0_dbg_gnt", bus.dbg_gnt, 32'h0);
        nc(); bus.cpu_req = 1'b0;
        smp();
        chk("tie0_no_gnt_busy", bus.dbg_gnt, 32'h0);
        chk("tie0_addr", mem_address, 32'h100);
        nc(); smp();
        nc(); smp();
        chk("tie0_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid}, 32'h2);
        chk("tie0_rdata", bus.rdata, 32'h1111_1111);
        nc();
        bus.cpu_req = 1'b1;
        mem_word_output = 32'h2222_2222;
        smp();
        chk("tie4_dbg_gnt", bus.dbg_gnt, 32'h1);
        chk("tie4_cpu_gnt", bus.cpu_gnt, 32'h0);
        nc(); bus.dbg_req = 1'b0;
        smp();
        chk("tie4_addr", mem_address, 32'h200);
        nc(); smp();
        nc(); smp();
        chk("tie4_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid}, 32'h1);
        chk("tie4_rdata", bus.rdata, 32'h2222_2222);
        nc();
        bus.dbg_req = 1'b1;
        smp();
        chk("tie8_gnt", {bus.cpu_gnt, bus.dbg_gnt}, 32'h2);
        nc();
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        nc(); nc(); nc();

        // single cpu read
        req_cpu(1, 2'b00, 32'h10, 32'h0);
        mem_word_output = 32'hDEAD_BEEF;
        smp();
        chk("rd_gnt", bus.cpu_gnt, 32'h1);
        nc(); bus.cpu_req = 1'b0;
        smp();
        chk("rd_addr", mem_address, 32'h10);
        chk("rd_c1_rvalid", bus.cpu_rvalid, 32'h0);
        nc(); smp();
        chk("rd_c2_rvalid", bus.cpu_rvalid, 32'h0);
        nc(); smp();
        chk("rd_c3_rvalid", {bus.cpu_rvalid, bus.cpu_err}, 32'h2);
        chk("rd_c3_rdata", bus.rdata, 32'hDEAD_BEEF);
        nc(); smp();
        chk("rd_c4_idle", {bus.cpu_rvalid, bus.rdata}, 33'h0);

        // dbg VGA word write
        nc();
        req_dbg(1, 2'b11, 32'h0002_0040, 32'h1234_5678);
        smp();
        chk("vga_gnt", bus.dbg_gnt, 32'h1);
        nc(); bus.dbg_req = 1'b0;
        smp();
        chk("vga_en_c1", vga_write_en, 32'h1);
        chk("vga_waddr", vga_write_address, 32'h040);
        chk("vga_wdata", vga_input_data, 32'h1234_5678);
        chk("vga_no_mem", mem_write_mode, 32'h0);
        nc(); smp();
        chk("vga_en_c2", vga_write_en, 32'h0);
        chk("vga_resp", {bus.dbg_rvalid, bus.dbg_err, bus.cpu_rvalid}, 32'h4);

        // misaligned half write
        nc();
        req_cpu(1, 2'b10, 32'h3, 32'hBEEF);
        smp();
        chk("mis_gnt", bus.cpu_gnt, 32'h1);
        nc(); bus.cpu_req = 1'b0;
        smp();
        chk("mis_resp", {bus.cpu_rvalid, bus.cpu_err}, 32'h3);
        chk("mis_no_side", {mem_write_mode, vga_write_en}, 32'h0);

        // read at RAM_LIMIT is illegal
        nc();
        req_cpu(1, 2'b00, 32'h0002_0000, 32'h0);
        smp();
        nc(); bus.cpu_req = 1'b0;
        smp();
        chk("rdill_resp", {bus.cpu_rvalid, bus.cpu_err}, 32'h3);
        chk("rdill_rdata", bus.rdata, 32'h0);

        // RAM word write completing with mem_done
        nc();
        req_cpu(1, 2'b11, 32'h40, 32'hCAFE_F00D);
        smp();
        nc(); bus.cpu_req = 1'b0; mem_done = 1'b1;
        smp();
        chk("wr_mode", mem_write_mode, 32'h3);
        chk("wr_word", mem_write_word, 32'hCAFE_F00D);
        nc(); mem_done = 1'b0;
        smp();
        chk("wr_resp", {bus.cpu_rvalid, bus.cpu_err}, 32'h2);
        chk("wr_mode_clr", mem_write_mode, 32'h0);

        // RAM byte write timeout
        nc();
        req_cpu(1, 2'b01, 32'h20, 32'h0000_00AB);
        smp();
        nc(); bus.cpu_req = 1'b0;
        smp();
        chk("to_mode", mem_write_mode, 32'h1);
        chk("to_byte", mem_write_byte, 32'hAB);
        n = 1;
        while (!bus.cpu_rvalid && n < 400) begin
            nc(); smp();
            n++;
        end
        chk("to_cycle", n, 32'd256);
        chk("to_err", bus.cpu_err, 32'h1);
        chk("to_mode_clr", mem_write_mode, 32'h0);

        // done and error together: error wins
        nc();
        req_dbg(1, 2'b10, 32'h30, 32'h0000_5A5A);
        smp();
        nc(); bus.dbg_req = 1'b0;
        smp();
        chk("de_half", mem_write_half_word, 32'h5A5A);
        nc(); mem_done = 1'b1; mem_error = 1'b1;
        smp();
        chk("de_wait", bus.dbg_rvalid, 32'h0);
        nc(); mem_done = 1'b0; mem_error = 1'b0;
        smp();
        chk("de_resp", {bus.dbg_rvalid, bus.dbg_err}, 32'h3);

        // reset during READ_WAIT
        nc();
        req_cpu(1, 2'b00, 32'h50, 32'h0);
        smp();
        nc(); bus.cpu_req = 1'b0; rst = 1'b1;
        smp();
        nc(); rst = 1'b0;
        smp();
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_outs", {bus.cpu_rvalid, bus.dbg_rvalid, bus.rdata, mem_write_mode, vga_write_en}, 32'h0);
        nc(); smp();
        chk("rst_no_resp", {bus.cpu_rvalid, bus.dbg_rvalid}, 32'h0);
        nc();
        req_cpu(1, 2'b00, 32'h60, 32'h0);
        req_dbg(1, 2'b00, 32'h70, 32'h0);
        smp();
        chk("rst_tie_gnt", {bus.cpu_gnt, bus.dbg_gnt}, 32'h2);
        nc();
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        nc(); nc(); nc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
